// File: rtl/fp_pkg.sv
// Shared encodings and helpers for the parametrised floating-point arithmetic unit.
package fp_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_RSV = 2'd3
    } fp_op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_EXEC   = 3'd2,
        S_NORM   = 3'd3,
        S_DONE   = 3'd4
    } fp_state_e;

    localparam int FLAG_UNF = 0;
    localparam int FLAG_OVF = 1;
    localparam int FLAG_INV = 2;
    localparam int FLAG_W   = 3;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN, right-aligned in 64 bits; callers truncate to their word width.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_arith_unit_if.sv
// Operand/result handshake bundle between the register file, the FP unit and writeback.
interface fp_arith_unit_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [2:0]   flags;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/fp_normalize_round.sv
// Combinational normalise + round-to-nearest-even + overflow/underflow packing.
// man_i carries two integer bits at the top: value = man_i * 2^(exp_i - bias - (NW-2)).
module fp_normalize_round #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W  = EXP_W + MAN_W + 1,
    localparam int NW = 2 * (MAN_W + 1),
    localparam int EW = EXP_W + 3
) (
    input  logic                 sign_i,
    input  logic signed [EW-1:0] exp_i,
    input  logic [NW-1:0]        man_i,
    output logic [W-1:0]         result_o,
    output logic                 ovf_o,
    output logic                 unf_o
);
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

    logic [EW-1:0]        lz;
    logic [NW-1:0]        shifted;
    logic signed [EW-1:0] e_n, e_f;
    logic [MAN_W-1:0]     frac;
    logic                 g, r, s, rup, carry;
    logic [MAN_W:0]       rnd;

    always_comb begin
        lz = '0;
        for (int i = 0; i < NW; i++) begin
            if (man_i[i]) lz = EW'(NW - 1 - i);
        end
    end

    always_comb begin
        shifted = man_i << lz;
        e_n     = exp_i - $signed(lz) + $signed(EW'(1));
        frac    = shifted[NW-2 -: MAN_W];
        g       = shifted[NW-2-MAN_W];
        r       = shifted[NW-3-MAN_W];
        s       = |shifted[NW-4-MAN_W:0];
        rup     = g & (r | s | frac[0]);
        rnd     = {1'b0, frac} + {{MAN_W{1'b0}}, rup};
        carry   = rnd[MAN_W];
        // A rounding carry leaves the fraction at zero and bumps the exponent.
        e_f     = e_n + $signed({{(EW-1){1'b0}}, carry});

        result_o = {sign_i, e_f[EXP_W-1:0], rnd[MAN_W-1:0]};
        ovf_o    = 1'b0;
        unf_o    = 1'b0;
        if (!shifted[NW-1]) begin
            result_o = '0;
        end else if (e_n[EW-1] || e_n == '0) begin
            result_o = {sign_i, {(W-1){1'b0}}};
            unf_o    = 1'b1;
        end else if (e_f >= EMAX) begin
            result_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf_o    = 1'b1;
        end
    end
endmodule

// File: rtl/fp_arith_unit.sv
// Multi-cycle FP add/sub/mul: IDLE -> UNPACK -> EXEC -> NORM -> DONE, one op in flight.
module fp_arith_unit
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = EXP_W + MAN_W + 1
) (
    input  logic           clk,
    input  logic           rst,
    fp_arith_unit_if.slave bus
);
    localparam int M    = MAN_W + 1;
    localparam int XW   = M + 3;
    localparam int NW   = 2 * M;
    localparam int EW   = EXP_W + 3;
    localparam int BIAS = fp_bias(EXP_W);
    localparam logic [W-1:0] QNAN = W'(fp_qnan(EXP_W, MAN_W));

    fp_state_e         state_q, state_d;
    logic [W-1:0]      result_q, result_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              in_ready_d, out_valid_d, accept;

    fp_op_e            op_q;
    logic [W-1:0]      a_q, b_q;

    logic [EXP_W-1:0]  ea_d, eb_d, ea_q, eb_q;
    logic [MAN_W-1:0]  fa_d, fb_d;
    logic [M-1:0]      ma_q, mb_q;
    logic              sa_q, sb_q, sb_d, mul_q;
    logic              za_q, zb_q, ia_q, ib_q, na_q, nb_q;

    logic                 n_sign_d, n_sign_q;
    logic signed [EW-1:0] n_exp_d, n_exp_q;
    logic [NW-1:0]        n_man_d, n_man_q;
    logic                 spec_d, spec_q, spec_inv_d, spec_inv_q;
    logic [W-1:0]         spec_res_d, spec_res_q;

    logic                 swap, sL, sS, eff_sub;
    logic [EXP_W-1:0]     eL, eS, diff;
    logic [M-1:0]         mL, mS;
    logic [XW-1:0]        extL, extS, alS;
    logic [XW:0]          sum;
    logic [NW-1:0]        prod;

    logic [W-1:0]         nr_res;
    logic                 nr_ovf, nr_unf;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_NORM) begin
                result_q <= result_d;
                flags_q  <= flags_d;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready_d = 1'b1;
                if (bus.in_valid) state_d = S_UNPACK;
            end
            S_UNPACK: state_d = S_EXEC;
            S_EXEC:   state_d = S_NORM;
            S_NORM:   state_d = S_DONE;
            S_DONE: begin
                out_valid_d = 1'b1;
                if (bus.out_ready) state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    assign accept        = bus.in_valid && (state_q == S_IDLE);
    assign bus.in_ready  = in_ready_d;
    assign bus.out_valid = out_valid_d;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

    always_comb begin
        ea_d = a_q[W-2:MAN_W];
        eb_d = b_q[W-2:MAN_W];
        fa_d = a_q[MAN_W-1:0];
        fb_d = b_q[MAN_W-1:0];
        sb_d = b_q[W-1] ^ (op_q == OP_SUB);
    end

    // Alignment and mantissa arithmetic; special operands override below.
    always_comb begin
        swap    = {ea_q, ma_q} < {eb_q, mb_q};
        eL      = swap ? eb_q : ea_q;
        eS      = swap ? ea_q : eb_q;
        mL      = swap ? mb_q : ma_q;
        mS      = swap ? ma_q : mb_q;
        sL      = swap ? sb_q : sa_q;
        sS      = swap ? sa_q : sb_q;
        eff_sub = sL ^ sS;
        diff    = eL - eS;
        extL    = {mL, 3'b000};
        extS    = {mS, 3'b000};
        if ({{(32-EXP_W){1'b0}}, diff} > 32'(MAN_W + 3))
            alS = {{(XW-1){1'b0}}, |mS};
        else
            alS = (extS >> diff) | {{(XW-1){1'b0}}, |(extS & ~({XW{1'b1}} << diff))};
        sum  = eff_sub ? ({1'b0, extL} - {1'b0, alS}) : ({1'b0, extL} + {1'b0, alS});
        prod = NW'(ma_q) * NW'(mb_q);

        if (mul_q) begin
            n_sign_d = sa_q ^ sb_q;
            n_exp_d  = $signed({{(EW-EXP_W){1'b0}}, ea_q}) + $signed({{(EW-EXP_W){1'b0}}, eb_q})
                     - $signed(EW'(BIAS));
            n_man_d  = prod;
        end else begin
            n_sign_d = sL;
            n_exp_d  = $signed({{(EW-EXP_W){1'b0}}, eL});
            n_man_d  = {sum, {(NW-XW-1){1'b0}}};
        end

        spec_d     = 1'b1;
        spec_inv_d = 1'b0;
        spec_res_d = QNAN;
        if (na_q || nb_q) begin
            spec_inv_d = 1'b1;
        end else if (mul_q) begin
            if ((ia_q && zb_q) || (ib_q && za_q)) spec_inv_d = 1'b1;
            else if (ia_q || ib_q) spec_res_d = {sa_q ^ sb_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            else if (za_q || zb_q) spec_res_d = {sa_q ^ sb_q, {(W-1){1'b0}}};
            else spec_d = 1'b0;
        end else begin
            if (ia_q && ib_q && (sa_q != sb_q)) spec_inv_d = 1'b1;
            else if (ia_q) spec_res_d = {sa_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            else if (ib_q) spec_res_d = {sb_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            else if (za_q && zb_q) spec_res_d = {sa_q & sb_q, {(W-1){1'b0}}};
            else spec_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= fp_op_e'(bus.op);
            a_q  <= bus.a;
            b_q  <= bus.b;
        end
        if (state_q == S_UNPACK) begin
            sa_q  <= a_q[W-1];
            sb_q  <= sb_d;
            ea_q  <= ea_d;
            eb_q  <= eb_d;
            ma_q  <= (ea_d == '0) ? '0 : {1'b1, fa_d};
            mb_q  <= (eb_d == '0) ? '0 : {1'b1, fb_d};
            za_q  <= (ea_d == '0);
            zb_q  <= (eb_d == '0);
            ia_q  <= (&ea_d) && (fa_d == '0);
            ib_q  <= (&eb_d) && (fb_d == '0);
            na_q  <= (&ea_d) && (|fa_d);
            nb_q  <= (&eb_d) && (|fb_d);
            mul_q <= (op_q == OP_MUL);
        end
        if (state_q == S_EXEC) begin
            n_sign_q   <= n_sign_d;
            n_exp_q    <= n_exp_d;
            n_man_q    <= n_man_d;
            spec_q     <= spec_d;
            spec_inv_q <= spec_inv_d;
            spec_res_q <= spec_res_d;
        end
    end

    fp_normalize_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_norm (
        .sign_i   (n_sign_q),
        .exp_i    (n_exp_q),
        .man_i    (n_man_q),
        .result_o (nr_res),
        .ovf_o    (nr_ovf),
        .unf_o    (nr_unf)
    );

    always_comb begin
        flags_d = '0;
        if (spec_q) begin
            result_d          = spec_res_q;
            flags_d[FLAG_INV] = spec_inv_q;
        end else begin
            result_d          = nr_res;
            flags_d[FLAG_OVF] = nr_ovf;
            flags_d[FLAG_UNF] = nr_unf;
        end
    end
endmodule

// File: tb/tb_fp_arith_unit.sv
// Scoreboard bench: single- and half-precision instances driven with hand-computed vectors.
module tb_fp_arith_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_arith_unit_if #(.W(32)) b32();
    fp_arith_unit_if #(.W(16)) b16();

    fp_arith_unit #(.EXP_W(8), .MAN_W(23)) u32 (.clk(clk), .rst(rst), .bus(b32));
    fp_arith_unit #(.EXP_W(5), .MAN_W(10)) u16 (.clk(clk), .rst(rst), .bus(b16));

    int errors = 0;
    int checks = 0;
    logic [34:0] q32[$];
    logic [18:0] q16[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    logic [34:0] e32;
    always @(negedge clk) begin
        if (!rst && b32.out_valid && b32.out_ready) begin
            if (q32.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious32: got result %h, required no output", b32.result);
            end else begin
                e32 = q32.pop_front();
                check("res32 {result,flags}", {29'b0, b32.result, b32.flags}, {29'b0, e32});
            end
        end
    end

    logic [18:0] e16;
    always @(negedge clk) begin
        if (!rst && b16.out_valid && b16.out_ready) begin
            if (q16.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious16: got result %h, required no output", b16.result);
            end else begin
                e16 = q16.pop_front();
                check("res16 {result,flags}", {45'b0, b16.result, b16.flags}, {45'b0, e16});
            end
        end
    end

    task automatic issue32(input string nm, input logic [1:0] o, input logic [31:0] x, y, er,
                           input logic [2:0] ef);
        int n = 0;
        @(negedge clk);
        while (!b32.in_ready && n < 50) begin @(negedge clk); n++; end
        if (!b32.in_ready) begin
            checks++; errors++;
            $display("FAIL %s: in_ready stayed 0, required 1", nm);
        end
        b32.op = o; b32.a = x; b32.b = y; b32.in_valid = 1'b1;
        q32.push_back({er, ef});
        @(posedge clk); #1;
        b32.in_valid = 1'b0; b32.a = $urandom; b32.b = $urandom; b32.op = 2'($urandom);
        n = 0;
        do begin @(negedge clk); n++; end while (!b32.out_valid && n < 20);
        check({nm, " latency"}, 64'(n), 64'd4);
    endtask

    task automatic issue16(input logic [1:0] o, input logic [15:0] x, y, er, input logic [2:0] ef);
        int n = 0;
        @(negedge clk);
        while (!b16.in_ready && n < 50) begin @(negedge clk); n++; end
        b16.op = o; b16.a = x; b16.b = y; b16.in_valid = 1'b1;
        q16.push_back({er, ef});
        @(posedge clk); #1;
        b16.in_valid = 1'b0; b16.a = 16'($urandom); b16.b = 16'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        b32.in_valid = 1'b0; b32.op = 2'd0; b32.a = '0; b32.b = '0; b32.out_ready = 1'b1;
        b16.in_valid = 1'b0; b16.op = 2'd0; b16.a = '0; b16.b = '0; b16.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", 64'(b32.in_ready), 64'd1);
        check("reset out_valid", 64'(b32.out_valid), 64'd0);
        check("reset result", 64'(b32.result), 64'd0);
        check("reset flags", 64'(b32.flags), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        issue32("add 34+96",    2'd0, 32'h42080000, 32'h42C00000, 32'h43020000, 3'b000);
        issue32("add -789+512", 2'd0, 32'hC4454000, 32'h44000000, 32'hC38A8000, 3'b000);
        issue32("sub 96-34",    2'd1, 32'h42C00000, 32'h42080000, 32'h42780000, 3'b000);
        issue32("mul 34*96",    2'd2, 32'h42080000, 32'h42C00000, 32'h454C0000, 3'b000);
        issue32("add 0+x",      2'd0, 32'h00000000, 32'h4CDBDC31, 32'h4CDBDC31, 3'b000);
        issue32("add cancel",   2'd0, 32'h460B8FF2, 32'hC60B8FF2, 32'h00000000, 3'b000);
        issue32("inf-inf",      2'd0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 3'b100);
        issue32("mul ovf",      2'd2, 32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010);
        issue32("mul unf",      2'd2, 32'h00800000, 32'h00800000, 32'h00000000, 3'b001);
        issue32("nan in",       2'd0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b100);
        issue32("0*inf",        2'd2, 32'h00000000, 32'h7F800000, 32'h7FC00000, 3'b100);
        issue32("-inf+1",       2'd0, 32'hFF800000, 32'h3F800000, 32'hFF800000, 3'b000);
        issue32("-0+-0",        2'd0, 32'h80000000, 32'h80000000, 32'h80000000, 3'b000);
        issue32("sub 0-1",      2'd1, 32'h00000000, 32'h3F800000, 32'hBF800000, 3'b000);
        issue32("tie even",     2'd0, 32'h3F800000, 32'h33800000, 32'h3F800000, 3'b000);
        issue32("tie odd",      2'd0, 32'h3F800001, 32'h33800000, 32'h3F800002, 3'b000);
        issue32("subnormal",    2'd0, 32'h00000001, 32'h3F800000, 32'h3F800000, 3'b000);
        issue32("op3 as add",   2'd3, 32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000);

        // Backpressure: hold the result for 10 cycles while new requests knock.
        @(posedge clk); #1 b32.out_ready = 1'b0;
        issue32("bp add", 2'd0, 32'h42080000, 32'h42C00000, 32'h43020000, 3'b000);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin b32.in_valid = 1'b1; b32.a = 32'h3F800000; b32.b = 32'h3F800000; end
            check("bp hold {ov,ir,result,flags}",
                  {29'b0, b32.out_valid, b32.in_ready, b32.result, b32.flags},
                  {29'b0, 1'b1, 1'b0, 32'h43020000, 3'b000});
            @(negedge clk);
        end
        @(posedge clk); #1 b32.in_valid = 1'b0; b32.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp release in_ready", 64'(b32.in_ready), 64'd1);
        check("bp release out_valid", 64'(b32.out_valid), 64'd0);

        // Reset while the operation sits in EXEC.
        @(negedge clk);
        b32.op = 2'd0; b32.a = 32'h42080000; b32.b = 32'h42C00000; b32.in_valid = 1'b1;
        @(posedge clk); #1 b32.in_valid = 1'b0;
        @(posedge clk); #1;
        check("exec in_ready", 64'(b32.in_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort out_valid", 64'(b32.out_valid), 64'd0);
        check("abort in_ready", 64'(b32.in_ready), 64'd1);
        check("abort result", 64'(b32.result), 64'd0);
        repeat (8) @(negedge clk);

        // rst beats a simultaneous request.
        rst = 1'b1; b32.in_valid = 1'b1;
        @(posedge clk); #1 rst = 1'b0; b32.in_valid = 1'b0;
        @(negedge clk);
        check("rst+valid in_ready", 64'(b32.in_ready), 64'd1);
        repeat (8) @(negedge clk);
        check("rst+valid out_valid", 64'(b32.out_valid), 64'd0);

        issue32("post reset 1+1", 2'd0, 32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000);

        issue16(2'd0, 16'h3C00, 16'h4000, 16'h4200, 3'b000);
        issue16(2'd2, 16'h3C00, 16'h3E00, 16'h3E00, 3'b000);
        issue16(2'd1, 16'h4200, 16'h3C00, 16'h4000, 3'b000);

        repeat (12) @(negedge clk);
        check("q32 drained", 64'(q32.size()), 64'd0);
        check("q16 drained", 64'(q16.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fp_arith_unit.md
Name: fp_arith_unit

Overview:
Parametrised, multi-cycle floating-point arithmetic unit. It supersedes the combinational single-precision FP_Adder/FP_Multiplier pair with one block that has:
- parametrised exponent and mantissa widths;
- add, sub and mul modes;
- valid/ready handshakes on input and output;
- IEEE special-value handling and status flags.

It sits between the operand register file and the result writeback stage of the CA datapath.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 23, stored fraction width (hidden bit excluded)
W, EXP_W+MAN_W+1, total word width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operands/op valid
in_ready  output  1  unit can accept an operation
op  input  2  0=add, 1=sub (a-b), 2=mul, 3=reserved (treated as add)
a  input  W  operand A, IEEE-style packed
b  input  W  operand B, IEEE-style packed
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  W  packed result
flags  output  3  {invalid, overflow, underflow}, held with result

Behaviour:
- Reset state: all outputs 0 and FSM in IDLE, except in_ready, which is 1.
- FSM states: IDLE -> UNPACK -> EXEC -> NORM -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - When in_valid && in_ready, op, a and b are registered and the FSM moves to UNPACK.
  - in_ready=0 in every other state. Only one operation is in flight.
- UNPACK:
  - Split sign, exponent and fraction; insert the hidden bit.
  - exp==0 marks the operand as zero; subnormals are flushed to signed zero.
  - exp all-ones marks Inf (frac==0) or NaN.
  - sub mode inverts the sign of b.
- EXEC:
  - add/sub: swap so |A|>=|B|. Right-shift B's mantissa by the exponent difference, keeping guard, round and sticky bits; a difference greater than MAN_W+3 leaves only sticky. Add or subtract the mantissas per effective sign.
  - mul: sign = sa^sb; exponent = ea+eb-bias; mantissa = (MAN_W+1)x(MAN_W+1) product.
- NORM:
  - Leading-zero count and single-cycle barrel shift to normalise.
  - Round to nearest, ties to even, using guard/round/sticky. A rounding carry renormalises.
- DONE:
  - out_valid=1; result and flags are stable.
  - Both hold until out_ready is sampled 1, then the FSM returns to IDLE with out_valid=0.
- Latency: 4 cycles from the accept edge to out_valid; throughput is one operation per 5 cycles with out_ready tied high.
- Special cases:
  - Any NaN input, Inf-Inf (effective), or 0*Inf: result is canonical qNaN (sign 0, exp all-ones, frac MSB 1, rest 0), invalid=1.
  - Inf with finite: signed Inf.
  - Exact-zero sum: +0 (round-to-nearest rule); -0 + -0 = -0.
  - Exponent overflow after rounding: signed Inf, overflow=1.
  - Exponent <= 0 after normalisation: signed zero, underflow=1.
- Inputs a, b and op are ignored outside the accept cycle.
- rst in any state aborts the operation next edge: outputs return to reset values and no result is emitted.
- If in_valid and rst are both high, rst wins and nothing is accepted.

Decomposition:
- Package fp_pkg holds:
  - op encodings: OP_ADD, OP_SUB, OP_MUL;
  - FSM state encodings;
  - flag bit indices;
  - a function computing the bias and canonical qNaN for given EXP_W/MAN_W.
- One sub-module, fp_normalize_round: combinational LZC, shift, RNE rounding and overflow/underflow detection. It is parametrised by EXP_W/MAN_W and instantiated in the NORM stage.

Test Plan:
- add 34 (0x42080000) + 96 (0x42C00000), out_ready=1 -> result 0x43020000 (130), flags 000, out_valid exactly 4 cycles after accept.
- add -789 (0xC4454000) + 512 (0x44000000) -> 0xC38A8000 (-277); sub 96-34 -> 0x42780000 (62).
- mul 34*96 -> 0x454C0000 (3264); add 0 + 0x4CDBDC31 -> 0x4CDBDC31; add 0x460B8FF2 + 0xC60B8FF2 -> 0x00000000.
- Specials:
  - add 0x7F800000 + 0xFF800000 -> 0x7FC00000, invalid=1;
  - mul 0x7F000000 * 0x7F000000 -> 0x7F800000, overflow=1;
  - mul 0x00800000 * 0x00800000 -> 0x00000000, underflow=1.
- Backpressure and reset:
  - hold out_ready=0 for 10 cycles after out_valid -> result/flags stable, in_ready=0, new in_valid ignored; release -> one handshake, back to IDLE.
  - assert rst during EXEC -> next cycle out_valid=0, in_ready=1, no result emitted.
- Parametrisation: EXP_W=5, MAN_W=10 (half) -> 1.0 (0x3C00) + 2.0 (0x4000) = 0x4200; 1.0*1.5 (0x3E00) = 0x3E00.
